seq_multiplier_param: RTL and testbench

Iterative radix-2^DIGIT shift-and-add multiplier, parametrised in operand width and digit size, with a signed/unsigned mode select and optional early termination.
Uses a valid/ready handshake on both input and output, so producers and consumers can stall it.
Replaces the fixed 32-bit nibble multiplier as the multiply unit behind the team's datapath exercises and arithmetic blocks.

---
 rtl/seq_multiplier_param.sv | 143 ++++++++++++++
 tb/tb_seq_multiplier_param.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier_param.sv
`timescale 1ns/1ps
// seq_multiplier_param: iterative radix-2^DIGIT shift-and-add multiplier.
// The multiplier and multiplicand are converted to magnitudes on acceptance.
// DIGIT multiplier bits are folded into the accumulator each RUN cycle.
// The sign is applied once, when the product is registered into r.
module seq_multiplier_param #(
    parameter int WIDTH      = 32,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    output logic                 ready_in,
    input  logic                 signed_in,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic [2*WIDTH-1:0]   r,
    output logic                 busy
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    // Reject parameter combinations the digit-serial datapath cannot handle.
    if (WIDTH < 2) begin : g_bad_width
        $error("seq_multiplier_param: WIDTH must be >= 2");
    end
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("seq_multiplier_param: DIGIT must divide WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mp_q, mp_d;
    logic [2*WIDTH-1:0]   mc_q, mc_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   r_q, r_d;

    logic [2*WIDTH-1:0]   pp;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mp_sh;
    logic                 last;

    // |x| as an unsigned WIDTH-bit value; -(2^(WIDTH-1)) maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    // Restores the product sign from the unsigned accumulated magnitude.
    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] x,
                                                      input logic               neg);
        return neg ? -x : x;
    endfunction

    // State and datapath registers; every register clears on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mp_q    <= '0;
            mc_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            mp_q    <= mp_d;
            mc_q    <= mc_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            r_q     <= r_d;
        end
    end

    // Next-state logic: operand capture, one digit step per RUN cycle, handoff.
    always_comb begin
        state_d = state_q;
        mp_d    = mp_q;
        mc_d    = mc_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        r_d     = r_q;
        pp      = '0;
        acc_sum = '0;
        mp_sh   = '0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    mp_d    = magnitude(a, signed_in);
                    mc_d    = {{WIDTH{1'b0}}, magnitude(b, signed_in)};
                    neg_d   = signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The true partial product never exceeds 2*WIDTH bits, so truncation is exact.
                pp      = mc_q * {{(2*WIDTH-DIGIT){1'b0}}, mp_q[DIGIT-1:0]};
                acc_sum = acc_q + pp;
                mp_sh   = mp_q >> DIGIT;
                last    = (cnt_q == CNT_W'(STEPS - 1)) ||
                          ((EARLY_EXIT != 0) && (mp_sh == '0));
                acc_d   = acc_sum;
                mp_d    = mp_sh;
                mc_d    = mc_q << DIGIT;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last) begin
                    r_d     = apply_sign(acc_sum, neg_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready_out) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready_in  = (state_q == IDLE);
    assign valid_out = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign r         = r_q;

endmodule

// File: tb/tb_seq_multiplier_param.sv
`timescale 1ns/1ps
// Testbench for seq_multiplier_param: four instances (W=32 D=4 with and
// without early exit, W=8 D=2 early exit, W=8 D=1 fixed latency).
module tb_seq_multiplier_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 32-bit instances share inputs
    logic        vin32 = 1'b0, sgn32 = 1'b0, ro32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        rdy_e, vo_e, busy_e, rdy_n, vo_n, busy_n;
    logic [63:0] r_e, r_n;

    // 8-bit instances share inputs
    logic        vin8 = 1'b0, sgn8 = 1'b0, ro8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        rdy_p, vo_p, busy_p, rdy_q, vo_q, busy_q;
    logic [15:0] r_p, r_q;

    seq_multiplier_param #(.WIDTH(32), .DIGIT(4), .EARLY_EXIT(1)) dut_e (
        .clk(clk), .rst(rst), .valid_in(vin32), .ready_in(rdy_e), .signed_in(sgn32),
        .a(a32), .b(b32), .valid_out(vo_e), .ready_out(ro32), .r(r_e), .busy(busy_e));
    seq_multiplier_param #(.WIDTH(32), .DIGIT(4), .EARLY_EXIT(0)) dut_n (
        .clk(clk), .rst(rst), .valid_in(vin32), .ready_in(rdy_n), .signed_in(sgn32),
        .a(a32), .b(b32), .valid_out(vo_n), .ready_out(ro32), .r(r_n), .busy(busy_n));
    seq_multiplier_param #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) dut_p (
        .clk(clk), .rst(rst), .valid_in(vin8), .ready_in(rdy_p), .signed_in(sgn8),
        .a(a8), .b(b8), .valid_out(vo_p), .ready_out(ro8), .r(r_p), .busy(busy_p));
    seq_multiplier_param #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(0)) dut_q (
        .clk(clk), .rst(rst), .valid_in(vin8), .ready_in(rdy_q), .signed_in(sgn8),
        .a(a8), .b(b8), .valid_out(vo_q), .ready_out(ro8), .r(r_q), .busy(busy_q));

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] r;
        int          k;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference product: plain signed or unsigned arithmetic at double width.
    function automatic logic [63:0] ref32(input logic s, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy;
        if (s) begin
            sx = $signed(x);
            sy = $signed(y);
            return 64'(sx * sy);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    function automatic logic [15:0] ref8(input logic s, input logic [7:0] x, input logic [7:0] y);
        logic signed [15:0] sx, sy;
        if (s) begin
            sx = $signed(x);
            sy = $signed(y);
            return 16'(sx * sy);
        end
        return {8'b0, x} * {8'b0, y};
    endfunction

    // Reference latency from the bit length of the multiplier magnitude.
    function automatic int ref_k(input logic ee, input int w, input int d,
                                 input logic s, input logic [31:0] x);
        longint v;
        int     bl;
        int     k;
        if (!ee) return w / d;
        v = longint'(x) & ((longint'(1) << w) - 1);
        if (s && v >= (longint'(1) << (w - 1))) v = (longint'(1) << w) - v;
        bl = 0;
        while (v > 0) begin
            bl++;
            v = v >> 1;
        end
        k = (bl + d - 1) / d;
        if (k < 1) k = 1;
        return k;
    endfunction

    // One transaction on both 32-bit instances; k = cycles from acceptance edge to valid_out.
    task automatic run32(input logic s, input logic [31:0] x, input logic [31:0] y,
                         output logic [63:0] re, output logic [63:0] rn,
                         output int ke, output int kn);
        @(negedge clk);
        chk("ready_in_idle32", 64'({rdy_e, rdy_n}), 64'(2'b11));
        sgn32 = s; a32 = x; b32 = y; vin32 = 1'b1;
        @(posedge clk);
        #1 vin32 = 1'b0;
        ke = -1; kn = -1; re = '0; rn = '0;
        for (int c = 1; c <= 40 && (ke < 0 || kn < 0); c++) begin
            @(posedge clk);
            #1;
            if (ke < 0 && vo_e) begin ke = c; re = r_e; end
            if (kn < 0 && vo_n) begin kn = c; rn = r_n; end
        end
        ro32 = 1'b1;
        @(posedge clk);
        #1 ro32 = 1'b0;
        chk("valid_out_drop32", 64'({vo_e, vo_n}), 64'(2'b00));
        chk("ready_in_back32", 64'({rdy_e, rdy_n}), 64'(2'b11));
    endtask

    task automatic run8(input logic s, input logic [7:0] x, input logic [7:0] y,
                        output logic [15:0] rp, output logic [15:0] rq,
                        output int kp, output int kq);
        @(negedge clk);
        sgn8 = s; a8 = x; b8 = y; vin8 = 1'b1;
        @(posedge clk);
        #1 vin8 = 1'b0;
        kp = -1; kq = -1; rp = '0; rq = '0;
        for (int c = 1; c <= 20 && (kp < 0 || kq < 0); c++) begin
            @(posedge clk);
            #1;
            if (kp < 0 && vo_p) begin kp = c; rp = r_p; end
            if (kq < 0 && vo_q) begin kq = c; rq = r_q; end
        end
        ro8 = 1'b1;
        @(posedge clk);
        #1 ro8 = 1'b0;
    endtask

    initial begin
        logic [63:0] re, rn;
        logic [15:0] rp, rq;
        int          ke, kn, kp, kq;
        logic        s;
        logic [31:0] x, y;
        logic [7:0]  x8, y8;
        int          seen;

        tbl[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 8};
        tbl[1] = '{1'b0, 32'd3,        32'd5,        64'd15,               1};
        tbl[2] = '{1'b0, 32'h100,      32'd7,        64'h700,              3};
        tbl[3] = '{1'b0, 32'd0,        32'h1234,     64'd0,                1};
        tbl[4] = '{1'b1, 32'hFFFFFFFD, 32'd7,        64'hFFFFFFFFFFFFFFEB, 1};
        tbl[5] = '{1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 8};

        // Reset state
        #12;
        chk("rst_ready_in", 64'(rdy_e), 64'(1));
        chk("rst_valid_out", 64'({vo_e, vo_n, vo_p, vo_q}), 64'(0));
        chk("rst_busy", 64'({busy_e, busy_n, busy_p, busy_q}), 64'(0));
        chk("rst_r", r_e | r_n | 64'(r_p) | 64'(r_q), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            run32(tbl[i].s, tbl[i].a, tbl[i].b, re, rn, ke, kn);
            chk($sformatf("vec%0d_r_early", i), re, tbl[i].r);
            chk($sformatf("vec%0d_r_fixed", i), rn, tbl[i].r);
            chk($sformatf("vec%0d_k_early", i), 64'(ke), 64'(tbl[i].k));
            chk($sformatf("vec%0d_k_fixed", i), 64'(kn), 64'(8));
        end

        // Backpressure: 6*7 held in DONE while new operands are offered
        @(negedge clk);
        sgn32 = 1'b0; a32 = 32'd6; b32 = 32'd7; vin32 = 1'b1;
        @(posedge clk);
        #1 vin32 = 1'b0;
        for (int c = 0; c < 20 && !vo_n; c++) begin
            @(posedge clk);
            #1;
        end
        chk("bp_both_done", 64'({vo_e, vo_n}), 64'(2'b11));
        vin32 = 1'b1; a32 = 32'd99; b32 = 32'd99;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 64'({vo_e, vo_n}), 64'(2'b11));
            chk("bp_hold_r", r_e, 64'd42);
            chk("bp_hold_ready_in", 64'({rdy_e, rdy_n}), 64'(0));
        end
        vin32 = 1'b0;
        ro32 = 1'b1;
        @(posedge clk);
        #1 ro32 = 1'b0;
        chk("bp_release_valid", 64'({vo_e, vo_n}), 64'(0));
        chk("bp_release_ready_in", 64'({rdy_e, rdy_n}), 64'(2'b11));
        chk("bp_r_retained", r_n, 64'd42);
        chk("bp_busy_low", 64'({busy_e, busy_n}), 64'(0));

        // Asynchronous reset mid-RUN
        @(negedge clk);
        sgn32 = 1'b0; a32 = 32'h12345678; b32 = 32'd9; vin32 = 1'b1;
        @(posedge clk);
        #1 vin32 = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid_out", 64'({vo_e, vo_n}), 64'(0));
        chk("arst_busy", 64'({busy_e, busy_n}), 64'(0));
        chk("arst_r", r_e | r_n, 64'(0));
        chk("arst_ready_in", 64'({rdy_e, rdy_n}), 64'(2'b11));
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (vo_e || vo_n) seen++;
        end
        chk("arst_no_stale_pulse", 64'(seen), 64'(0));
        run32(1'b0, 32'd9, 32'd9, re, rn, ke, kn);
        chk("arst_9x9_early", re, 64'd81);
        chk("arst_9x9_fixed", rn, 64'd81);
        chk("arst_9x9_k_early", 64'(ke), 64'(1));
        chk("arst_9x9_k_fixed", 64'(kn), 64'(8));

        // Random 32-bit against the reference model
        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom_range(0, 1));
            x = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) x = -x;
            y = $urandom;
            run32(s, x, y, re, rn, ke, kn);
            chk("rand32_r_early", re, ref32(s, x, y));
            chk("rand32_r_fixed", rn, ref32(s, x, y));
            chk("rand32_k_early", 64'(ke), 64'(ref_k(1'b1, 32, 4, s, x)));
            chk("rand32_k_fixed", 64'(kn), 64'(ref_k(1'b0, 32, 4, s, x)));
        end

        // 8-bit corners then random sweep
        for (int i = 0; i < 305; i++) begin
            case (i)
                0: begin s = 1'b1; x8 = 8'h80; y8 = 8'h80; end
                1: begin s = 1'b1; x8 = 8'h80; y8 = 8'h7F; end
                2: begin s = 1'b0; x8 = 8'hFF; y8 = 8'hFF; end
                3: begin s = 1'b1; x8 = 8'hFF; y8 = 8'hFF; end
                4: begin s = 1'b0; x8 = 8'h00; y8 = 8'h5A; end
                default: begin
                    s  = 1'($urandom_range(0, 1));
                    x8 = 8'($urandom_range(0, 255));
                    y8 = 8'($urandom_range(0, 255));
                end
            endcase
            run8(s, x8, y8, rp, rq, kp, kq);
            chk("w8_d2_r", 64'(rp), 64'(ref8(s, x8, y8)));
            chk("w8_d1_r", 64'(rq), 64'(ref8(s, x8, y8)));
            chk("w8_d2_k", 64'(kp), 64'(ref_k(1'b1, 8, 2, s, {24'b0, x8})));
            chk("w8_d1_k", 64'(kq), 64'(ref_k(1'b0, 8, 1, s, {24'b0, x8})));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
